alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `alu` between `N_REQ` requesters, such as the execute stage and the branch/address unit. Each requester has a valid/ready request channel and a valid/ready response channel. The block grants one request per cycle using round-robin order and drives the winner's op and operands into the ALU. It captures `alu_result_i` into a one-entry response register that is returned to the owning requester with backpressure.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the response owner index.
- `clk_i` input 1: clock, rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `req_valid_i` input N_REQ: request valid, one bit per requester.
- `req_ready_o` output N_REQ: request accepted this cycle; at most one bit set.
- `req_op_i` input N_REQ×`ALU_OP_WIDTH`: per-requester ALU op.
- `req_a_i` input N_REQ×`RISCV_WORD_WIDTH`: per-requester operand A.
- `req_b_i` input N_REQ×`RISCV_WORD_WIDTH`: per-requester operand B.
- `resp_valid_o` output N_REQ: response valid, one-hot to the owner.
- `resp_ready_i` input N_REQ: per-requester response ready.
- `resp_data_o` output `RISCV_WORD_WIDTH`: registered ALU result.
- `resp_id_o` output ID_W: owner index of the held response.
- `alu_op_o` output `ALU_OP_WIDTH`: to `alu.alu_op_i`.
- `alu_a_o` output `RISCV_WORD_WIDTH`: to `alu.operand_a_i`.
- `alu_b_o` output `RISCV_WORD_WIDTH`: to `alu.operand_b_i`.
- `alu_result_i` input `RISCV_WORD_WIDTH`: from `alu.alu_result_o`.

## Operation
- **Response register.** State is `full`, `data`, `id`, plus round-robin pointer `last` (index of the most recent accepted grant).
- **Drain.** `drain = full & resp_ready_i[id]`.
- **Accept condition.** `can_accept = !full | drain`.
- **Grant.** Grant goes to the first valid requester scanning `last+1, last+2, …` modulo N_REQ.
  - `req_ready_o[g] = can_accept` for the granted index `g`; all other ready bits are 0.
  - With no valid request, all ready bits are 0.
- **ALU drive.**
  - A grant exists: ALU inputs carry the granted op and operands, independent of `can_accept`.
  - No grant: ALU is driven with `ALU_ADD`, 0, 0, so it never sees X.
- **Handshake.** A handshake is `req_valid_i[g] & req_ready_o[g]`. On a handshake:
  - `data <= alu_result_i`, `id <= g`, `full <= 1`, `last <= g`.
- **Drain without new handshake.** `full <= 0`.
- **Drain and handshake in the same cycle.** The new entry is loaded (`full` stays 1). This gives full throughput of one operation per cycle.
- **Response outputs.** `resp_valid_o = full ? onehot(id) : 0`.
- **Requester rules.**
  - A requester holds valid, op and operands stable until ready.
  - A requester's `req_valid_i` must not depend combinationally on `req_ready_o`.
  - The arbiter never drops or reorders an accepted request.
- **Stall.** While `full & !drain`, all ready bits are 0 and `last` is frozen. The grant index may change as `req_valid_i` changes, but no handshake occurs.
- **Illegal op.** An op outside the ALU op set is passed through unchanged. The result is whatever the ALU produces; no checking is done here.

## Timing
- Reset (async assert, sync release) gives:
  - `full=0`, `data=0`, `id=0`.
  - `last=N_REQ-1`, so requester 0 wins first.
  - All `req_ready_o` and `resp_valid_o` bits are 0.
- Latency: handshake in cycle N gives `resp_valid_o` high in cycle N+1. `resp_data_o` equals the ALU result computed in cycle N.
- Throughput: 1 per cycle while the owner keeps `resp_ready_i` high.
- `req_ready_o` and the ALU drive are combinational from `req_valid_i`, `resp_ready_i` and state.
  - Critical path: request mux → `alu` → response register.
  - There is no combinational path from `req_*` to `resp_*`.
- Reset mid-operation: a held response is discarded and the pointer returns to its reset value. Requesters re-issue.
- Single requester continuously valid with its response always ready: granted every cycle.
- All requesters continuously valid: each wins once per N_REQ accepted grants.

## Structure
- `alu_arb_pkg` holds:
  - `alu_req_t` struct {op, a, b}.
  - `ALU_IDLE_OP = ALU_ADD`.
  - The one-hot/index helper function.
- `ALU_OP_WIDTH`, `RISCV_WORD_WIDTH` and the op encodings stay in the existing defines includes.
- Sub-module `rr_arbiter`: combinational, parametrized N.
  - Inputs: `valid[N]`, `last`.
  - Outputs: `grant_onehot[N]`, `grant_idx`, `any`.
  - It is reusable for other shared resources.
- The response register and pointer update live in `alu_arbiter`. The `alu` is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** assert `rst_ni=0` mid-run with `full=1` → all outputs 0 immediately. After release, requester 0 wins first when requesters 0 and 1 are both valid.
- **Single ADD:** requester 0 sends `ALU_ADD` 5+7 with `resp_ready=1` → ready in cycle 0; in cycle 1 `resp_valid_o=01`, `resp_data_o=12`, `resp_id_o=0`.
- **Round-robin:** both requesters continuously valid (req0 SUB 10−3, req1 XOR F0^0F), responses always ready → grants 0,1,0,1…; responses alternate 7, FF, 7, FF at one per cycle.
- **Backpressure:** requester 1 response with `resp_ready_i[1]=0` for 3 cycles and requester 0 valid → `req_ready_o=00` for those cycles, `resp_data_o` held.
  - On the cycle `resp_ready_i[1]` rises, requester 0 is accepted.
  - Its result appears the next cycle with no bubble.
- **Comparison ops:** `ALU_LTS` with A=0xFFFFFFFF, B=1 → result 0xFFFFFFFF.
  - `ALU_LTS` is encoded as `~(gt|eq)`, so "true" is all-ones.
  - `ALU_EQ` with 3,3 → result 1.
  - Confirms operand and op passthrough.
- **Idle drive:** no requests valid → `alu_op_o=ALU_ADD`, `alu_a_o=alu_b_o=0`, `resp_valid_o` deasserts after the last drain. Randomized valid/ready with a scoreboard checks no loss, no duplication and in-order responses per requester.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU request arbiter.
// The ALU width and op encodings mirror the core's RISC-V defines.
package alu_arb_pkg;

  localparam int ALU_OP_WIDTH     = 4;
  localparam int RISCV_WORD_WIDTH = 32;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ  = 4'd9;

  // Op presented to the ALU when nobody is requesting, keeps its inputs X-free.
  localparam logic [ALU_OP_WIDTH-1:0] ALU_IDLE_OP = ALU_ADD;

  // Largest requester count the one-hot helper supports.
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0]     op;
    logic [RISCV_WORD_WIDTH-1:0] a;
    logic [RISCV_WORD_WIDTH-1:0] b;
  } alu_req_t;

  // Index to one-hot over the maximum requester count; callers truncate.
  function automatic logic [MAX_REQ-1:0] onehot_from_idx(input logic [2:0] idx);
    onehot_from_idx = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first valid index after `last_i`
// (wrapping modulo N) wins. Reusable for any shared resource.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     grant_onehot_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N);

  logic [IDX_W:0]   pos_s;
  logic [IDX_W-1:0] cand_s;

  // Scan last+1 .. last+N modulo N and latch the first valid candidate.
  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    any_o          = 1'b0;
    pos_s          = '0;
    cand_s         = '0;
    for (int off = 1; off <= N; off++) begin
      pos_s  = {1'b0, last_i} + (IDX_W+1)'(off);
      pos_s  = (pos_s >= N_L) ? (pos_s - N_L) : pos_s;
      cand_s = pos_s[IDX_W-1:0];
      if (!any_o && valid_i[cand_s]) begin
        any_o                  = 1'b1;
        grant_idx_o            = cand_s;
        grant_onehot_o[cand_s] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters. The round-robin
// winner drives the ALU; its result is captured into a one-entry response
// register returned to the owner with backpressure. A drain and a new grant
// may happen in the same cycle, giving one operation per cycle.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [N_REQ-1:0]                        req_valid_i,
  output logic [N_REQ-1:0]                        req_ready_o,
  input  logic [N_REQ-1:0][ALU_OP_WIDTH-1:0]      req_op_i,
  input  logic [N_REQ-1:0][RISCV_WORD_WIDTH-1:0]  req_a_i,
  input  logic [N_REQ-1:0][RISCV_WORD_WIDTH-1:0]  req_b_i,
  output logic [N_REQ-1:0]                        resp_valid_o,
  input  logic [N_REQ-1:0]                        resp_ready_i,
  output logic [RISCV_WORD_WIDTH-1:0]             resp_data_o,
  output logic [ID_W-1:0]                         resp_id_o,
  output logic [ALU_OP_WIDTH-1:0]                 alu_op_o,
  output logic [RISCV_WORD_WIDTH-1:0]             alu_a_o,
  output logic [RISCV_WORD_WIDTH-1:0]             alu_b_o,
  input  logic [RISCV_WORD_WIDTH-1:0]             alu_result_i
);

  logic                        full_q, full_d;
  logic [RISCV_WORD_WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0]             id_q, id_d;
  logic [ID_W-1:0]             last_q, last_d;

  logic [N_REQ-1:0] grant_oh_s;
  logic [ID_W-1:0]  grant_idx_s;
  logic             grant_any_s;
  logic             drain_s;
  logic             can_accept_s;
  logic             hs_s;
  alu_req_t         alu_req_s;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .valid_i        (req_valid_i),
    .last_i         (last_q),
    .grant_onehot_o (grant_oh_s),
    .grant_idx_o    (grant_idx_s),
    .any_o          (grant_any_s)
  );

  // The held response leaves when its owner is ready; a free slot takes a new grant.
  assign drain_s      = full_q & resp_ready_i[id_q];
  assign can_accept_s = ~full_q | drain_s;
  // Reset gating keeps ready low while the block is held in reset.
  assign hs_s         = grant_any_s & can_accept_s & rst_ni;

  // Ready goes only to the winner, and only when the response slot can take it.
  always_comb begin
    if (rst_ni && can_accept_s) begin
      req_ready_o = grant_oh_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // Steer the winner to the ALU regardless of slot state; idle op otherwise.
  always_comb begin
    if (grant_any_s) begin
      alu_req_s.op = req_op_i[grant_idx_s];
      alu_req_s.a  = req_a_i[grant_idx_s];
      alu_req_s.b  = req_b_i[grant_idx_s];
    end else begin
      alu_req_s.op = ALU_IDLE_OP;
      alu_req_s.a  = '0;
      alu_req_s.b  = '0;
    end
  end

  assign alu_op_o = alu_req_s.op;
  assign alu_a_o  = alu_req_s.a;
  assign alu_b_o  = alu_req_s.b;

  // Next-state for the response slot and the round-robin pointer.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    id_d   = id_q;
    last_d = last_q;
    if (hs_s) begin
      full_d = 1'b1;
      data_d = alu_result_i;
      id_d   = grant_idx_s;
      last_d = grant_idx_s;
    end else if (drain_s) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Response slot and pointer registers; pointer resets so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      last_q <= ID_W'(N_REQ - 1);
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

  // Response valid is one-hot to the owner of the held entry.
  always_comb begin
    if (full_q) begin
      resp_valid_o = N_REQ'(onehot_from_idx(3'(id_q)));
    end else begin
      resp_valid_o = '0;
    end
  end

  assign resp_data_o = data_q;
  assign resp_id_o   = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural model of the arbitration rules.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N    = 2;
  localparam int W    = RISCV_WORD_WIDTH;
  localparam int OPW  = ALU_OP_WIDTH;
  localparam int ID_W = $clog2(N);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_valid, req_ready, resp_valid, resp_ready;
  logic [N-1:0][OPW-1:0] req_op;
  logic [N-1:0][W-1:0]   req_a, req_b;
  logic [W-1:0]          resp_data;
  logic [ID_W-1:0]       resp_id;
  logic [OPW-1:0]        alu_op;
  logic [W-1:0]          alu_a, alu_b, alu_result;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   ref_last = N - 1;

  alu_arbiter #(.N_REQ(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_id_o    (resp_id),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_result_i (alu_result)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Behaviour of the shared ALU; comparisons return all-ones, EQ returns 1.
  function automatic logic [W-1:0] alu_ref(input logic [OPW-1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      ALU_ADD: alu_ref = a + b;
      ALU_SUB: alu_ref = a - b;
      ALU_XOR: alu_ref = a ^ b;
      ALU_OR:  alu_ref = a | b;
      ALU_AND: alu_ref = a & b;
      ALU_SLL: alu_ref = a << b[4:0];
      ALU_SRL: alu_ref = a >> b[4:0];
      ALU_LTS: alu_ref = ($signed(a) < $signed(b)) ? 32'hFFFF_FFFF : 32'h0;
      ALU_LTU: alu_ref = (a < b) ? 32'hFFFF_FFFF : 32'h0;
      ALU_EQ:  alu_ref = (a == b) ? 32'd1 : 32'd0;
      default: alu_ref = a ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  // Stand-in for the external ALU driven by the arbiter.
  always_comb alu_result = alu_ref(alu_op, alu_a, alu_b);

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor/scoreboard: model the slot and round-robin rules and compare every cycle.
  logic [N-1:0] m_exp_valid, m_exp_ready;
  logic         m_drain, m_can, m_any;
  int           m_g, m_c;
  exp_t         m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      ref_last = N - 1;
      check("reset_req_ready", W'(req_ready), W'(0));
      check("reset_resp_valid", W'(resp_valid), W'(0));
    end else begin
      m_exp_valid = '0;
      if (sb_q.size() > 0) m_exp_valid[sb_q[0].id] = 1'b1;
      check("resp_valid", W'(resp_valid), W'(m_exp_valid));
      if (sb_q.size() > 0) begin
        check("resp_data", resp_data, sb_q[0].data);
        check("resp_id", W'(resp_id), W'(sb_q[0].id));
      end
      m_drain = (sb_q.size() > 0) && resp_ready[sb_q[0].id];
      m_can   = (sb_q.size() == 0) || m_drain;
      m_any   = 1'b0;
      m_g     = 0;
      for (int k = 1; k <= N; k++) begin
        m_c = (ref_last + k) % N;
        if (!m_any && req_valid[m_c]) begin
          m_any = 1'b1;
          m_g   = m_c;
        end
      end
      m_exp_ready = '0;
      if (m_any && m_can) m_exp_ready[m_g] = 1'b1;
      check("req_ready", W'(req_ready), W'(m_exp_ready));
      if (m_any) begin
        check("alu_op", W'(alu_op), W'(req_op[m_g]));
        check("alu_a", alu_a, req_a[m_g]);
        check("alu_b", alu_b, req_b[m_g]);
      end else begin
        check("idle_op", W'(alu_op), W'(ALU_ADD));
        check("idle_a", alu_a, 32'h0);
        check("idle_b", alu_b, 32'h0);
      end
      if (m_drain) void'(sb_q.pop_front());
      if (m_any && m_can) begin
        m_e.id   = m_g;
        m_e.data = alu_ref(req_op[m_g], req_a[m_g], req_b[m_g]);
        sb_q.push_back(m_e);
        ref_last = m_g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OPW-1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[i] = op;
    req_a[i]  = a;
    req_b[i]  = b;
  endtask

  logic [OPW-1:0] ops [11];
  logic [N-1:0]   acc;

  // Stimulus: directed scenarios, then random traffic obeying the hold rule.
  initial begin
    ops = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL,
            ALU_SRL, ALU_LTS, ALU_LTU, ALU_EQ, 4'hF};
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single ADD 5+7.
    step();
    req_valid = 2'b01; set_req(0, ALU_ADD, 32'd5, 32'd7); resp_ready = 2'b11;
    @(negedge clk); check("add_ready", W'(req_ready), W'(2'b01));
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("add_valid", W'(resp_valid), W'(2'b01));
    check("add_data", resp_data, 32'd12);
    check("add_id", W'(resp_id), 32'd0);
    check("idle_drive_op", W'(alu_op), W'(ALU_ADD));
    step();
    @(negedge clk); check("add_drained", W'(resp_valid), W'(2'b00));

    // Round-robin: last winner was 0, so requester 1 goes first.
    for (int i = 0; i < 6; i++) begin
      step();
      req_valid = 2'b11;
      set_req(0, ALU_SUB, 32'd10, 32'd3);
      set_req(1, ALU_XOR, 32'hF0, 32'h0F);
      @(negedge clk);
      check("rr_ready", W'(req_ready), (i % 2 == 0) ? 32'd2 : 32'd1);
      if (i > 0) check("rr_data", resp_data, (i % 2 == 1) ? 32'hFF : 32'd7);
    end
    step(); req_valid = 2'b00;
    @(negedge clk); check("rr_last_data", resp_data, 32'd7);

    // Backpressure on requester 1's response.
    step(); req_valid = 2'b10; resp_ready = 2'b01;
    @(negedge clk); check("bp_grant1", W'(req_ready), W'(2'b10));
    step(); req_valid = 2'b01; set_req(0, ALU_ADD, 32'd5, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall_ready", W'(req_ready), W'(2'b00));
      check("bp_held_data", resp_data, 32'hFF);
      if (i < 2) step();
    end
    step(); resp_ready = 2'b11;
    @(negedge clk); check("bp_release_ready", W'(req_ready), W'(2'b01));
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("bp_no_bubble_valid", W'(resp_valid), W'(2'b01));
    check("bp_no_bubble_data", resp_data, 32'd12);

    // Comparison ops.
    step(); req_valid = 2'b01; set_req(0, ALU_LTS, 32'hFFFF_FFFF, 32'd1);
    step(); req_valid = 2'b10; set_req(1, ALU_EQ, 32'd3, 32'd3);
    @(negedge clk); check("lts_data", resp_data, 32'hFFFF_FFFF);
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("eq_data", resp_data, 32'd1);
    check("eq_id", W'(resp_id), 32'd1);

    // Reset while a response is held.
    step(); req_valid = 2'b11; resp_ready = 2'b00;
    set_req(0, ALU_ADD, 32'd1, 32'd2); set_req(1, ALU_ADD, 32'd3, 32'd4);
    step();
    @(negedge clk); check("pre_reset_full", W'(resp_valid), W'(2'b01));
    #2 rst_n = 1'b0;
    #1;
    check("rst_resp_valid", W'(resp_valid), W'(0));
    check("rst_req_ready", W'(req_ready), W'(0));
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_id", W'(resp_id), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; resp_ready = 2'b11;
    @(negedge clk); check("post_reset_first", W'(req_ready), W'(2'b01));

    // Randomized traffic.
    acc = req_valid & req_ready;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_req(i, ops[$urandom_range(0, 10)],
                  ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 8)) : W'($urandom()),
                  ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 8)) : W'($urandom()));
        end
      end
      for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = req_valid & req_ready;
    end

    // Drain and confirm nothing is left outstanding.
    step(); req_valid = '0; resp_ready = 2'b11;
    repeat (3) step();
    @(negedge clk);
    check("final_resp_idle", W'(resp_valid), W'(0));
    check("final_sb_empty", W'(sb_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
